// File: rtl/sample_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sample_uart_tx
// Description : Sample FIFO feeding a UART-style serialiser
//               (start, LSB-first data, optional even parity, stop).
// Revision    : 1.0 - initial release
// ============================================================================
module sample_uart_tx #(
  parameter int DATA_IN_LEN  = 10,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_POWER   = 2,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_IN_LEN-1:0] data_in,
  input  logic                   strobe_in,
  output logic                   tx,
  output logic                   busy,
  output logic [FIFO_POWER:0]    fifo_level,
  output logic                   overflow
);

  localparam int c_DEPTH  = 2 ** FIFO_POWER;
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_BIT_W  = (DATA_IN_LEN > 1) ? $clog2(DATA_IN_LEN) : 1;
  localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST  = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0]    c_BIT_LAST   = c_BIT_W'(DATA_IN_LEN - 1);
  localparam logic [FIFO_POWER:0]   c_LEVEL_FULL = (FIFO_POWER + 1)'(c_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [c_BAUD_W-1:0]      baud_q, baud_d;
  logic [c_BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_IN_LEN-1:0]   shift_q, shift_d;
  logic                     parity_q, parity_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic [FIFO_POWER:0]      level_q, level_d;
  logic [FIFO_POWER-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_POWER-1:0]    rd_ptr_q, rd_ptr_d;
  logic                     overflow_q, overflow_d;
  logic [DATA_IN_LEN-1:0]   mem_q [c_DEPTH];

  logic                     pop;
  logic                     push;
  logic                     fifo_full;
  logic                     baud_last;
  logic [DATA_IN_LEN-1:0]   head;

  assign head = mem_q[rd_ptr_q];

  // A pop frees the head slot on the same edge, so a push into a full FIFO
  // is still accepted when it coincides with the IDLE->START transition.
  always_comb begin
    pop        = (state_q == S_IDLE) && (level_q != '0);
    fifo_full  = (level_q == c_LEVEL_FULL);
    push       = strobe_in && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
    if (strobe_in && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    baud_last = (baud_q == c_BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          state_d  = S_START;
          shift_d  = head;
          parity_d = ^head;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == c_BIT_LAST) begin
            bit_d   = '0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Line level is decoded from the next state so tx leaves a flop.
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_uart_tx
// Description : Scoreboard bench for sample_uart_tx; a line monitor decodes
//               each frame and compares it with the queued samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_uart_tx;

  localparam int W     = 10;
  localparam int CPB   = 4;
  localparam int FP    = 2;
  localparam int NBITS = 13;
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          strobe_in = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          tx;
  logic          busy;
  logic [FP:0]   fifo_level;
  logic          overflow;

  sample_uart_tx #(
    .DATA_IN_LEN (W),
    .CLKS_PER_BIT(CPB),
    .FIFO_POWER  (FP),
    .PARITY_EN   (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .strobe_in (strobe_in),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] sb[$];
  int           frames_seen = 0;
  bit           in_frame = 1'b0;
  bit           pend_at_end = 1'b0;
  bit           mon_unexp = 1'b0;
  int           idle_cnt = 0;
  int           mon_cnt = 0;
  int           cyc_err = 0;
  logic [NBITS-1:0] exp_frame = '0;
  logic [NBITS-1:0] obs_frame = '0;
  logic [W-1:0] mon_d = '0;

  // Frame layout, index 0 first on the line: start, data LSB-first, parity, stop.
  task automatic mon_loop();
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame    = 1'b0;
        idle_cnt    = 0;
        pend_at_end = 1'b0;
      end else begin
        if (!in_frame) begin
          if (tx === 1'b0) begin
            in_frame  = 1'b1;
            mon_cnt   = 0;
            obs_frame = '0;
            cyc_err   = 0;
            if (pend_at_end) begin
              n_tests++;
              if (idle_cnt !== 1) begin
                n_fail++;
                $display("FAIL frame_gap: idle cycles %0d, required 1", idle_cnt);
              end
            end
            pend_at_end = 1'b0;
            n_tests++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_frame: frame started with empty scoreboard at %0t", $time);
              mon_unexp = 1'b1;
              exp_frame = '0;
            end else begin
              mon_unexp = 1'b0;
              mon_d     = sb.pop_front();
              exp_frame = {1'b1, ^mon_d, mon_d, 1'b0};
            end
          end else begin
            idle_cnt++;
          end
        end
        if (in_frame) begin
          if (tx !== exp_frame[mon_cnt / CPB]) cyc_err++;
          if ((mon_cnt % CPB) == (CPB / 2)) obs_frame[mon_cnt / CPB] = tx;
          if (mon_cnt == FRAME - 1) begin
            frames_seen++;
            if (!mon_unexp) begin
              n_tests++;
              if (obs_frame !== exp_frame || cyc_err != 0) begin
                n_fail++;
                $display("FAIL frame: got bits %b (%0d bad cycles), required %b",
                         obs_frame, cyc_err, exp_frame);
              end
            end
            in_frame    = 1'b0;
            idle_cnt    = 0;
            pend_at_end = (sb.size() != 0);
          end
          mon_cnt++;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget, output int peak);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    peak = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (busy === 1'b0 && !in_frame && sb.size() == 0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: not idle after %0d cycles (busy=%b queued=%0d)", n, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_single();
    int f0;
    int hi;
    f0 = frames_seen;
    hi = 0;
    @(posedge clk); #1;
    data_in = 10'h2A5; strobe_in = 1'b1; sb.push_back(10'h2A5);
    @(posedge clk); #1 strobe_in = 1'b0;
    @(negedge clk);
    n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d, required 1", fifo_level); end
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_e: got %b, required 1", tx); end
    if (busy === 1'b1) hi++;
    @(negedge clk);
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL single_latency: tx got %b, required 0", tx); end
    if (busy === 1'b1) hi++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b1) hi++;
      else break;
    end
    n_tests++; if (hi != FRAME + 1) begin n_fail++; $display("FAIL single_busy_len: got %0d, required %0d", hi, FRAME + 1); end
    n_tests++; if (frames_seen != f0 + 1) begin n_fail++; $display("FAIL single_frames: got %0d, required 1", frames_seen - f0); end
  endtask

  task automatic test_burst3();
    logic [W-1:0] vals [3];
    int f0;
    int peak;
    vals[0] = 10'h3FF; vals[1] = 10'h000; vals[2] = 10'h155;
    f0 = frames_seen;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      data_in = vals[i]; strobe_in = 1'b1; sb.push_back(vals[i]);
    end
    @(posedge clk); #1 strobe_in = 1'b0;
    wait_idle(1000, peak);
    n_tests++; if (peak != 2) begin n_fail++; $display("FAIL burst3_peak: got %0d, required 2", peak); end
    n_tests++; if (frames_seen != f0 + 3) begin n_fail++; $display("FAIL burst3_frames: got %0d, required 3", frames_seen - f0); end
  endtask

  task automatic test_overflow();
    int f0;
    int peak;
    logic [W-1:0] v;
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      v = W'($urandom_range(0, 1023));
      data_in = v; strobe_in = 1'b1;
      if (i < 5) sb.push_back(v);
    end
    @(posedge clk); #1 strobe_in = 1'b0;
    @(negedge clk);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", overflow); end
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d, required 4", fifo_level); end
    wait_idle(2000, peak);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    n_tests++; if (frames_seen != f0 + 5) begin n_fail++; $display("FAIL ovf_frames: got %0d, required 5", frames_seen - f0); end
  endtask

  task automatic test_reset_mid();
    int  f0;
    int  lows;
    bit  seen;
    f0   = frames_seen;
    seen = 1'b0;
    @(posedge clk); #1;
    data_in = 10'h1C3; strobe_in = 1'b1; sb.push_back(10'h1C3);
    @(posedge clk); #1;
    data_in = 10'h0F0; sb.push_back(10'h0F0);
    @(posedge clk); #1 strobe_in = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rstmid_start: tx got %b, required a start bit", tx); end
    repeat (6) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1; sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b, required 1", tx); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d, required 0", fifo_level); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow: got %b, required 0", overflow); end
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_tests++; if (lows != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d non-idle cycles, required 0", lows); end
    n_tests++; if (frames_seen != f0) begin n_fail++; $display("FAIL rstmid_frames: got %0d, required 0", frames_seen - f0); end
  endtask

  task automatic test_full_pop();
    int f0;
    int peak;
    logic [W-1:0] v;
    f0 = frames_seen;
    // Pushes sampled at edges E..E+4; the first frame starts at E+1 and
    // returns to IDLE at E+53, so the next pop happens at edge E+54.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      v = W'($urandom_range(0, 1023));
      data_in = v; strobe_in = 1'b1; sb.push_back(v);
    end
    @(posedge clk); #1 strobe_in = 1'b0;
    @(negedge clk);
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fullpop_full: got %0d, required 4", fifo_level); end
    repeat (49) @(posedge clk);
    #1;
    v = 10'h2C7; data_in = v; strobe_in = 1'b1; sb.push_back(v);
    @(negedge clk);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL fullpop_idle: tx got %b, required 1", tx); end
    @(posedge clk); #1 strobe_in = 1'b0;
    @(negedge clk);
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fullpop_level: got %0d, required 4", fifo_level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow: got %b, required 0", overflow); end
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL fullpop_start: tx got %b, required 0", tx); end
    wait_idle(3000, peak);
    n_tests++; if (frames_seen != f0 + 6) begin n_fail++; $display("FAIL fullpop_frames: got %0d, required 6", frames_seen - f0); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf_end: got %b, required 0", overflow); end
  endtask

  initial begin
    fork
      mon_loop();
    join_none
    test_reset();
    test_single();
    test_burst3();
    test_overflow();
    test_reset_mid();
    test_full_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
